// File: rtl/wallace_mult_pipe.sv
// wallace_mult_pipe: pipelined Baugh-Wooley/Wallace multiplier; define WALLACE_MAC_ACC_EN to add a product accumulator
module wallace_mult_pipe #(
    parameter int WIDTH       = 8,
    parameter int PIPE_STAGES = 2
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 In_Valid,
    output logic                 In_Ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 Signed_Mode,
    output logic                 Out_Valid,
    input  logic                 Out_Ready,
    output logic [2*WIDTH-1:0]   Product
`ifdef WALLACE_MAC_ACC_EN
    ,
    input  logic                 Acc_Clr,
    output logic [2*WIDTH+7:0]   Acc_Out
`endif
);
    localparam int PW = 2 * WIDTH;
    localparam int NR = WIDTH + 1;
    localparam int RQ = (PIPE_STAGES > 1) ? PIPE_STAGES - 1 : 1;

    typedef logic [NR-1:0][PW-1:0] rows_t;

    function automatic int rows_at(int l);
        int n = NR;
        for (int i = 0; i < l; i++) n = n - n / 3;
        return n;
    endfunction

    function automatic int num_levels();
        int n = 0;
        for (int l = 0; l < 64; l++) if (rows_at(l) > 2) n = l + 1;
        return n;
    endfunction

    localparam int NL = num_levels();

    // Partial products; signed mode inverts the mixed sign terms and adds 1s at columns WIDTH and 2*WIDTH-1
    function automatic rows_t pp_gen(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic sm);
        rows_t r = '0;
        logic p;
        for (int j = 0; j < WIDTH; j++)
            for (int i = 0; i < WIDTH; i++) begin
                p = a[i] & b[j];
                if (sm && ((i == WIDTH - 1) != (j == WIDTH - 1))) p = ~p;
                r[j][i+j] = p;
            end
        if (sm) begin
            r[WIDTH][WIDTH] = 1'b1;
            r[WIDTH][PW-1]  = 1'b1;
        end
        return r;
    endfunction

    // One Wallace level: every full triple of rows becomes sum+carry, leftovers pass straight down
    function automatic rows_t csa(rows_t r, int n);
        rows_t o = '0;
        int t = n / 3;
        for (int g = 0; g < NR / 3; g++)
            if (g < t) begin
                o[2*g]   = r[3*g] ^ r[3*g+1] ^ r[3*g+2];
                o[2*g+1] = ((r[3*g] & r[3*g+1]) | (r[3*g] & r[3*g+2]) | (r[3*g+1] & r[3*g+2])) << 1;
            end
        for (int i = 0; i < NR; i++) if (i >= 3 * t && i < n) o[i-t] = r[i];
        return o;
    endfunction

    function automatic rows_t reduce(rows_t r, int lo, int hi);
        for (int l = 0; l < NL; l++) if (l >= lo && l < hi) r = csa(r, rows_at(l));
        return r;
    endfunction

    function automatic logic [PW-1:0] cpa(rows_t r);
        return r[0] + r[1];
    endfunction

    logic          en;
    logic          vld_q  [PIPE_STAGES];
    rows_t         rows_q [RQ];
    logic [PW-1:0] prod_q;

    assign en        = !(vld_q[PIPE_STAGES-1] && !Out_Ready);
    assign In_Ready  = en;
    assign Out_Valid = vld_q[PIPE_STAGES-1];
    assign Product   = prod_q;

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        localparam int LO = s * NL / PIPE_STAGES;
        localparam int HI = (s + 1) * NL / PIPE_STAGES;
        logic  vin;
        rows_t rin;
        if (s == 0) begin : g_src
            assign vin = In_Valid;
            assign rin = pp_gen(A, B, Signed_Mode);
        end else begin : g_src
            assign vin = vld_q[s-1];
            assign rin = rows_q[s-1];
        end
        // Valid bit advances with the pipe and freezes with it on a stall
        always_ff @(posedge Clk or negedge Rst_n)
            if (!Rst_n) vld_q[s] <= 1'b0;
            else if (en) vld_q[s] <= vin;
        if (s < PIPE_STAGES - 1) begin : g_csa
            // Carry-save rows after this stage's share of reduction levels
            always_ff @(posedge Clk or negedge Rst_n)
                if (!Rst_n) rows_q[s] <= '0;
                else if (en) rows_q[s] <= reduce(rin, LO, HI);
        end else begin : g_cpa
            // Final carry-propagate add; Product only changes when a result arrives
            always_ff @(posedge Clk or negedge Rst_n)
                if (!Rst_n) prod_q <= '0;
                else if (en && vin) prod_q <= cpa(reduce(rin, LO, HI));
        end
    end

`ifdef WALLACE_MAC_ACC_EN
    logic            sgn_q [PIPE_STAGES];
    logic [PW+7:0]   acc_q;
    logic [PW+7:0]   ext;
    logic            hs;

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_sgn
        logic sin;
        if (s == 0) begin : g_src
            assign sin = Signed_Mode;
        end else begin : g_src
            assign sin = sgn_q[s-1];
        end
        // Operand mode rides alongside its data so the accumulator knows how to extend
        always_ff @(posedge Clk or negedge Rst_n)
            if (!Rst_n) sgn_q[s] <= 1'b0;
            else if (en) sgn_q[s] <= sin;
    end

    assign hs      = Out_Valid && Out_Ready;
    assign ext     = {{8{sgn_q[PIPE_STAGES-1] & prod_q[PW-1]}}, prod_q};
    assign Acc_Out = acc_q;

    // Accumulate each delivered product; clear takes effect before the add
    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n) acc_q <= '0;
        else if (Acc_Clr || hs) acc_q <= (Acc_Clr ? '0 : acc_q) + (hs ? ext : '0);
`endif
endmodule

// File: tb/tb_wallace_mult_pipe.sv
// tb_wallace_mult_pipe: table and scoreboard checks for a 4-bit/2-stage and a 16-bit/3-stage multiplier
module tb_wallace_mult_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       iv, ir, sm, ov, ordy;
    logic [3:0] a, b;
    logic [7:0] prod;
    logic        iv16, ir16, sm16, ov16, ordy16;
    logic [15:0] a16, b16;
    logic [31:0] prod16;
`ifdef WALLACE_MAC_ACC_EN
    logic        acc_clr;
    logic [15:0] acc;
`endif

    int checks = 0;
    int errors = 0;
    int outs = 0;
    int cyc = 0;
    logic bp_en = 1'b0;
    logic [7:0]  q[$];
    logic [31:0] q16[$];

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       sm;
        logic [7:0] e;
    } vec_t;
    vec_t tbl [12];

    wallace_mult_pipe #(.WIDTH(4), .PIPE_STAGES(2)) u4 (
        .Clk(clk), .Rst_n(rst_n), .In_Valid(iv), .In_Ready(ir), .A(a), .B(b),
        .Signed_Mode(sm), .Out_Valid(ov), .Out_Ready(ordy), .Product(prod)
`ifdef WALLACE_MAC_ACC_EN
        , .Acc_Clr(acc_clr), .Acc_Out(acc)
`endif
    );

    wallace_mult_pipe #(.WIDTH(16), .PIPE_STAGES(3)) u16 (
        .Clk(clk), .Rst_n(rst_n), .In_Valid(iv16), .In_Ready(ir16), .A(a16), .B(b16),
        .Signed_Mode(sm16), .Out_Valid(ov16), .Out_Ready(ordy16), .Product(prod16)
`ifdef WALLACE_MAC_ACC_EN
        , .Acc_Clr(1'b0), .Acc_Out()
`endif
    );

    function automatic void check(string n, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endfunction

    function automatic logic [7:0] m4(logic [3:0] x, logic [3:0] y, logic s);
        logic signed [7:0] sx = $signed(x);
        logic signed [7:0] sy = $signed(y);
        logic [7:0] ux = x;
        logic [7:0] uy = y;
        return s ? 8'(sx * sy) : 8'(ux * uy);
    endfunction

    function automatic logic [31:0] m16(logic [15:0] x, logic [15:0] y, logic s);
        logic signed [31:0] sx = $signed(x);
        logic signed [31:0] sy = $signed(y);
        logic [31:0] ux = x;
        logic [31:0] uy = y;
        return s ? sx * sy : ux * uy;
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) if (bp_en) begin
        #1;
        ordy   = ($urandom_range(3) != 0);
        ordy16 = ($urandom_range(3) != 0);
    end

    always @(negedge clk) if (rst_n && ov && ordy) begin
        outs++;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL u4 unexpected output: got %0h expected none", prod);
        end else check("u4 product", prod, q.pop_front());
    end

    always @(negedge clk) if (rst_n && ov16 && ordy16) begin
        if (q16.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL u16 unexpected output: got %0h expected none", prod16);
        end else check("u16 product", prod16, q16.pop_front());
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] x, input logic [3:0] y, input logic s, input logic [7:0] e);
        int t = 0;
        a = x; b = y; sm = s; iv = 1'b1;
        @(negedge clk);
        while (!ir && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (ir) q.push_back(e);
        else begin
            checks++;
            errors++;
            $display("FAIL u4 accept timeout: got In_Ready=0 expected 1");
        end
        sync();
        iv = 1'b0;
    endtask

    task automatic send16(input logic [15:0] x, input logic [15:0] y, input logic s, input logic [31:0] e);
        int t = 0;
        a16 = x; b16 = y; sm16 = s; iv16 = 1'b1;
        @(negedge clk);
        while (!ir16 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (ir16) q16.push_back(e);
        else begin
            checks++;
            errors++;
            $display("FAIL u16 accept timeout: got In_Ready=0 expected 1");
        end
        sync();
        iv16 = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || q16.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("drain queue4", q.size(), 0);
        check("drain queue16", q16.size(), 0);
        sync();
    endtask

    task automatic wait_ov();
        int t = 0;
        @(negedge clk);
        while (!ov && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("wait out_valid", ov, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, o0, seen;
        iv = 0; a = 0; b = 0; sm = 0; ordy = 1;
        iv16 = 0; a16 = 0; b16 = 0; sm16 = 0; ordy16 = 1;
`ifdef WALLACE_MAC_ACC_EN
        acc_clr = 0;
`endif
        tbl[0]  = '{4'd15, 4'd15, 1'b0, 8'hE1};
        tbl[1]  = '{4'd8,  4'd8,  1'b1, 8'h40};
        tbl[2]  = '{4'd9,  4'd3,  1'b0, 8'h1B};
        tbl[3]  = '{4'd15, 4'd7,  1'b1, 8'hF9};
        tbl[4]  = '{4'd9,  4'd3,  1'b0, 8'h1B};
        tbl[5]  = '{4'd0,  4'd11, 1'b1, 8'h00};
        tbl[6]  = '{4'd7,  4'd7,  1'b0, 8'h31};
        tbl[7]  = '{4'd8,  4'd7,  1'b1, 8'hC8};
        tbl[8]  = '{4'd8,  4'd8,  1'b0, 8'h40};
        tbl[9]  = '{4'd15, 4'd15, 1'b1, 8'h01};
        tbl[10] = '{4'd8,  4'd15, 1'b0, 8'h78};
        tbl[11] = '{4'd15, 4'd8,  1'b1, 8'h08};

        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", ov, 0);
        check("reset product", prod, 0);
        check("reset out_valid16", ov16, 0);
        check("reset product16", prod16, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset in_ready", ir, 1);
        sync();

        send(4'd15, 4'd15, 1'b0, 8'hE1);
        @(negedge clk);
        check("latency after accept edge", ov, 0);
        @(negedge clk);
        check("latency out_valid", ov, 1);
        check("latency product", prod, 8'hE1);
        @(negedge clk);
        check("single-cycle out_valid", ov, 0);
        sync();

        t0 = cyc;
        for (int i = 0; i < 12; i++) send(tbl[i].a, tbl[i].b, tbl[i].sm, tbl[i].e);
        check("back-to-back accept cycles", cyc - t0, 12);
        drain();

        o0 = outs;
        fork
            begin
                send(4'd5,  4'd6, 1'b0, 8'h1E);
                send(4'd15, 4'd15, 1'b1, 8'h01);
                send(4'd7,  4'd9, 1'b0, 8'h3F);
                send(4'd12, 4'd4, 1'b1, 8'hF0);
            end
            begin
                int t;
                t = 0;
                sync();
                while (!ov && t < 50) begin
                    sync();
                    t++;
                end
                ordy = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall in_ready", ir, 0);
                    check("stall out_valid", ov, 1);
                    check("stall product held", prod, 8'h1E);
                end
                sync();
                ordy = 1'b1;
            end
        join
        drain();
        check("backpressure result count", outs - o0, 4);

        send(4'd3, 4'd3, 1'b0, 8'h09);
        send(4'd2, 4'd5, 1'b0, 8'h0A);
        #1;
        rst_n = 1'b0;
        #1;
        check("midflight reset out_valid", ov, 0);
        check("midflight reset product", prod, 0);
        q.delete();
        sync();
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (ov) seen++;
        end
        check("no output after reset", seen, 0);
        check("in_ready after reset", ir, 1);
        sync();

        bp_en = 1'b1;
        for (int s = 0; s < 2; s++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    send(4'(x), 4'(y), 1'(s), m4(4'(x), 4'(y), 1'(s)));
        bp_en = 1'b0;
        sync();
        ordy = 1'b1;
        ordy16 = 1'b1;
        drain();

        send16(16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
        send16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
        send16(16'h0000, 16'hABCD, 1'b1, 32'h0);
        bp_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [15:0] x, y;
            logic s;
            x = 16'($urandom);
            y = 16'($urandom);
            s = 1'($urandom);
            if ($urandom_range(7) == 0) sync();
            send16(x, y, s, m16(x, y, s));
        end
        bp_en = 1'b0;
        sync();
        ordy = 1'b1;
        ordy16 = 1'b1;
        drain();

`ifdef WALLACE_MAC_ACC_EN
        rst_n = 1'b0;
        sync();
        rst_n = 1'b1;
        check("acc reset", acc, 0);
        sync();
        send(4'd3, 4'd5, 1'b0, 8'h0F);
        wait_ov();
        @(negedge clk);
        check("acc unsigned 3x5", acc, 16'd15);
        sync();
        send(4'hE, 4'd3, 1'b1, 8'hFA);
        wait_ov();
        @(negedge clk);
        check("acc signed -2x3", acc, 16'd9);
        sync();
        send(4'd2, 4'd2, 1'b0, 8'h04);
        wait_ov();
        acc_clr = 1'b1;
        sync();
        acc_clr = 1'b0;
        check("acc clear with handshake", acc, 16'd4);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wallace_mult_pipe.md
Name: wallace_mult_pipe

Overview:
- Parametrised, pipelined Wallace-tree multiplier. It is the successor to the fixed 4x4 combinational tree.
- Computes WIDTH x WIDTH signed or unsigned products.
- Carry-save reduction is split across PIPE_STAGES register stages, with a valid/ready handshake on both sides.
- Sits between operand sources (ALU datapath, DSP front end) and a result consumer that can apply backpressure.

Parameters:
- WIDTH, 8, operand width in bits; legal range 4..32.
- PIPE_STAGES, 2, number of register stages from input acceptance to Out_Valid; legal range 1..4.

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  asynchronous active-low reset
- In_Valid  input  1  operands present on A, B, Signed_Mode
- In_Ready  output  1  block can accept operands this cycle
- A  input  WIDTH  multiplicand
- B  input  WIDTH  multiplier
- Signed_Mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled per transaction
- Out_Valid  output  1  Product is valid
- Out_Ready  input  1  consumer accepts Product this cycle
- Product  output  2*WIDTH  full-width product, no truncation

Behaviour:
- Reset: Rst_n low clears every stage valid bit, Out_Valid=0 and Product=0, without waiting for Clk.
  - In_Ready=1 from the first cycle after reset.
  - A reset mid-operation discards all in-flight transactions; nothing is emitted after release.
- Accept: a transaction is taken on a rising Clk when In_Valid && In_Ready.
  - A, B and Signed_Mode are captured together.
  - Signed_Mode travels down the pipe with its data, so mixed-mode back-to-back transactions are legal.
- Stall rule: stall = Out_Valid && !Out_Ready.
  - In_Ready = !stall.
  - When stall=1 no stage register or valid bit changes, Product is held stable, and In_Valid is ignored.
  - Bubbles are not collapsed; the whole pipe freezes.
- Latency: a transaction accepted at edge N presents Out_Valid=1 after edge N+PIPE_STAGES-1, provided no stall occurs in between.
  - With PIPE_STAGES=1, Out_Valid is asserted the cycle after acceptance.
  - Throughput is 1 per cycle with no stalls.
- Output: Out_Valid is cleared on the edge where Out_Ready=1 and no new result arrives from the previous stage.
  - Simultaneous drain and arrival keeps Out_Valid=1 and loads the new Product.
- Arithmetic, partial products:
  - Unsigned uses plain AND terms A[i]&B[j].
  - Signed uses Baugh-Wooley: sign-row and sign-column terms inverted, plus constant 1s at column WIDTH and column 2*WIDTH-1.
- Arithmetic, reduction:
  - Columns are reduced with full/half adders (3:2, 2:2) in Wallace order until 2 rows remain.
  - A final ripple or carry-propagate add produces the result modulo 2^(2*WIDTH).
- Stage split: reduction levels are distributed as evenly as possible across PIPE_STAGES.
  - The final carry-propagate add sits in the last stage.
  - Carry-save rows plus Signed_Mode are registered between stages.
- Corner results:
  - Signed: most-negative x most-negative = +2^(2*WIDTH-2), fits without overflow.
  - Unsigned: max x max = (2^WIDTH-1)^2.
  - Zero operands give Product=0.
- Out_Ready is don't-care while Out_Valid=0. In_Valid may drop at any time without a handshake penalty.

Optional Feature:
- Macro: WALLACE_MAC_ACC_EN.
- When defined, the block adds:
  - input Acc_Clr (1 bit);
  - output Acc_Out (2*WIDTH+8 bits, reset to 0).
- On every output handshake (Out_Valid && Out_Ready), Acc_Out += Product.
  - Product is sign-extended when that transaction's Signed_Mode=1, zero-extended otherwise.
  - Addition wraps modulo 2^(2*WIDTH+8).
- Acc_Clr=1 sets Acc_Out=0 on the edge. If it coincides with a handshake, Acc_Out=extended Product (clear then add).
- When the macro is undefined: no Acc_Clr or Acc_Out ports, no accumulator logic, and core behaviour is identical.

Test Plan:
- WIDTH=4, PIPE_STAGES=2, Out_Ready=1, unsigned 15x15 accepted at edge 0 -> Out_Valid=1 after edge 1, Product=0xE1 for exactly one cycle.
- WIDTH=4, Signed_Mode=1: -8x-8 -> Product=0x40; -1x7 -> 0xF9; 0x-5 -> 0x00. Streamed back-to-back, alternating with unsigned 9x3=0x1B; results return in order, one per cycle.
- Backpressure: stream 4 operand pairs, hold Out_Ready=0 for 5 cycles once Out_Valid=1 -> In_Ready=0, Product held constant, no loss or duplication; all 4 results emerge in order after release.
- Reset mid-flight: accept 2 transactions, pull Rst_n low between edges -> Out_Valid=0 and Product=0 immediately; no result appears after Rst_n rises; In_Ready=1.
- Exhaustive WIDTH=4 all 256 pairs x both modes, plus random WIDTH=16, PIPE_STAGES=3 against a behavioural multiply -> zero mismatches.
- With WALLACE_MAC_ACC_EN, WIDTH=4:
  - unsigned 3x5 then signed -2x3 -> Acc_Out=15 then 9;
  - Acc_Clr together with the handshake of 2x2 -> Acc_Out=4.
